acc_input_buffer: RTL
=====================

# acc_input_buffer

Request-driven input staging buffer sitting directly upstream of the accelerator core. It accepts feature-map words (one pixel across all channels) and weight words (all kernels × channels) from a valid/ready stream source into two independent FIFOs. On each core data request it pops one data word and one weight word together and presents them, registered, with valid strobes. It replaces the free-running stimulus generator once real memory feeds the core.

## Interface
- BIT_WIDTH, 8, element width
- NUM_CHANNEL, 3, channels per data word
- NUM_KERNEL, 4, kernels per weight word
- DEPTH, 16, entries per FIFO; power of two, ≥2
- REG_WIDTH, 32, width of the underflow counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_clear  in  1  synchronous flush of both FIFOs and counters
- s_data  in  BIT_WIDTH*NUM_CHANNEL  upstream data word
- s_data_val  in  1  upstream data valid
- s_data_rdy  out  1  data FIFO can accept
- s_weight  in  BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL  upstream weight word
- s_weight_val  in  1  upstream weight valid
- s_weight_rdy  out  1  weight FIFO can accept
- i_data_req  in  1  core request for next data/weight pair
- o_data  out  BIT_WIDTH*NUM_CHANNEL  data to core
- o_data_val  out  1  o_data valid strobe
- o_weight  out  BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL  weight to core
- o_weight_val  out  1  o_weight valid strobe
- o_data_cnt  out  log2(DEPTH)+1  data FIFO occupancy
- o_weight_cnt  out  log2(DEPTH)+1  weight FIFO occupancy
- o_underflow_cnt  out  REG_WIDTH  requests refused because a FIFO was empty

## Operation
- Two FIFOs, identical structure: write ptr, read ptr (log2(DEPTH) bits, natural wrap at DEPTH), occupancy counter 0..DEPTH.
- Push: s_x_val && s_x_rdy. s_x_rdy = !full && !rst && !i_clear (combinational from occupancy).
- Pop condition: i_data_req && data_cnt≠0 && weight_cnt≠0. Both FIFOs pop together; never one alone.
- Refused request: i_data_req with either FIFO empty -> no pop, o_underflow_cnt += 1, saturating at all-ones.
- Push and pop same cycle on same FIFO: both occur, occupancy unchanged.
- Full FIFO with simultaneous pop: s_x_rdy still low that cycle (ready does not look ahead).
- Empty FIFO with push and request same cycle: pushed word not visible; request refused and counted.
- o_data/o_weight hold the last popped word until the next pop; only the val strobes return low.
- i_clear: pointers, occupancies, underflow counter to 0, val strobes low; o_data/o_weight held; stored words discarded; i_clear has priority over push/pop in that cycle.
- Reset: as i_clear plus o_data = 0, o_weight = 0. All outputs: s_x_rdy 0 during rst, 1 first cycle after; cnts 0; underflow 0; vals 0.

## Timing
- Push at edge N -> occupancy +1 visible after edge N; word poppable by a request sampled at edge N+1.
- Pop sampled at edge N -> o_data, o_weight, o_data_val, o_weight_val updated at edge N (visible cycle N+1); val high exactly one cycle per pop.
- Back-to-back requests with data available -> one pair per cycle, vals continuously high.
- Underflow counter updates at the same edge the request is sampled.
- Throughput: one push per FIFO per cycle, one pair pop per cycle.

## Test plan
- Reset, then push data 0x201000, 0x201101, 0x201202 and weights 0..2, request 3 cycles -> o_data 0x201000/0x201101/0x201202 and o_weight 0/1/2 on consecutive cycles, vals high 3 cycles, cnts return to 0.
- Push 16 data words without request -> o_data_cnt 16, s_data_rdy 0; 17th valid not accepted; s_weight_rdy stays 1.
- Data FIFO holds 2 words, weight FIFO empty, request 2 cycles -> no pop, vals 0, o_data_cnt stays 2, o_underflow_cnt 2.
- Fill both to 8, then push+request every cycle for 40 cycles with incrementing values -> output order preserved across pointer wrap, cnts stay 8.
- Both full, request and push asserted same cycle -> one pair popped, push refused, cnts 15 after edge.
- Fill to 5, underflow_cnt 3, assert i_clear alongside push and request -> next cycle cnts 0, underflow 0, vals 0, o_data holds prior value; rst mid-stream -> o_data 0, rdy 0 during rst.

Source files
------------

// File: rtl/acc_input_buffer.sv
// acc_input_buffer
// Request-driven staging buffer in front of the accelerator core. Feature-map
// words and weight words arrive on two independent valid/ready streams and are
// held in two FIFOs of identical structure. Each core request pops one word
// from each FIFO together. The pair is presented on registered outputs with a
// one-cycle valid strobe.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_clear             synchronous flush of both FIFOs and the underflow count
//   s_data/_val/_rdy    upstream data stream (one pixel, all channels)
//   s_weight/_val/_rdy  upstream weight stream (all kernels x channels)
//   i_data_req          core request for the next data/weight pair
//   o_data/_val         popped data word and its strobe
//   o_weight/_val       popped weight word and its strobe
//   o_data_cnt          data FIFO occupancy (0..DEPTH)
//   o_weight_cnt        weight FIFO occupancy (0..DEPTH)
//   o_underflow_cnt     saturating count of refused requests
module acc_input_buffer #(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned NUM_CHANNEL = 3,
    parameter int unsigned NUM_KERNEL  = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned REG_WIDTH   = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_clear,
    input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]          s_data,
    input  logic                                      s_data_val,
    output logic                                      s_data_rdy,
    input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] s_weight,
    input  logic                                      s_weight_val,
    output logic                                      s_weight_rdy,
    input  logic                                      i_data_req,
    output logic [BIT_WIDTH*NUM_CHANNEL-1:0]          o_data,
    output logic                                      o_data_val,
    output logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] o_weight,
    output logic                                      o_weight_val,
    output logic [$clog2(DEPTH):0]                    o_data_cnt,
    output logic [$clog2(DEPTH):0]                    o_weight_cnt,
    output logic [REG_WIDTH-1:0]                      o_underflow_cnt
);

    localparam int unsigned DW    = BIT_WIDTH * NUM_CHANNEL;
    localparam int unsigned WW    = DW * NUM_KERNEL;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DW-1:0]        data_mem   [DEPTH];
    logic [WW-1:0]        weight_mem [DEPTH];

    logic [PTR_W-1:0]     data_wr_ptr_q,   data_wr_ptr_d;
    logic [PTR_W-1:0]     data_rd_ptr_q,   data_rd_ptr_d;
    logic [CNT_W-1:0]     data_cnt_q,      data_cnt_d;
    logic [PTR_W-1:0]     weight_wr_ptr_q, weight_wr_ptr_d;
    logic [PTR_W-1:0]     weight_rd_ptr_q, weight_rd_ptr_d;
    logic [CNT_W-1:0]     weight_cnt_q,    weight_cnt_d;
    logic [REG_WIDTH-1:0] underflow_q,     underflow_d;
    logic [DW-1:0]        data_out_q,      data_out_d;
    logic [WW-1:0]        weight_out_q,    weight_out_d;
    logic                 val_q,           val_d;

    logic data_push, weight_push, pair_avail, pop, refuse;

    // Ready looks only at current occupancy, so a full FIFO stays not-ready
    // even in a cycle where it is being popped.
    assign s_data_rdy   = (data_cnt_q   != CNT_W'(DEPTH)) && !rst && !i_clear;
    assign s_weight_rdy = (weight_cnt_q != CNT_W'(DEPTH)) && !rst && !i_clear;

    assign data_push   = s_data_val   && s_data_rdy;
    assign weight_push = s_weight_val && s_weight_rdy;

    // Both FIFOs must hold a word; a word pushed this cycle is not yet visible.
    assign pair_avail = (data_cnt_q != '0) && (weight_cnt_q != '0);
    assign pop        = i_data_req && pair_avail  && !i_clear;
    assign refuse     = i_data_req && !pair_avail && !i_clear;

    always_comb begin
        data_wr_ptr_d   = data_wr_ptr_q;
        data_rd_ptr_d   = data_rd_ptr_q;
        data_cnt_d      = data_cnt_q;
        weight_wr_ptr_d = weight_wr_ptr_q;
        weight_rd_ptr_d = weight_rd_ptr_q;
        weight_cnt_d    = weight_cnt_q;
        underflow_d     = underflow_q;
        data_out_d      = data_out_q;
        weight_out_d    = weight_out_q;
        val_d           = 1'b0;

        if (i_clear) begin
            // Output words are deliberately held across a flush.
            data_wr_ptr_d   = '0;
            data_rd_ptr_d   = '0;
            data_cnt_d      = '0;
            weight_wr_ptr_d = '0;
            weight_rd_ptr_d = '0;
            weight_cnt_d    = '0;
            underflow_d     = '0;
        end else begin
            if (data_push)   data_wr_ptr_d   = data_wr_ptr_q   + PTR_W'(1);
            if (weight_push) weight_wr_ptr_d = weight_wr_ptr_q + PTR_W'(1);

            if (pop) begin
                data_rd_ptr_d   = data_rd_ptr_q   + PTR_W'(1);
                weight_rd_ptr_d = weight_rd_ptr_q + PTR_W'(1);
                data_out_d      = data_mem[data_rd_ptr_q];
                weight_out_d    = weight_mem[weight_rd_ptr_q];
                val_d           = 1'b1;
            end

            case ({data_push, pop})
                2'b10:   data_cnt_d = data_cnt_q + CNT_W'(1);
                2'b01:   data_cnt_d = data_cnt_q - CNT_W'(1);
                default: data_cnt_d = data_cnt_q;
            endcase

            case ({weight_push, pop})
                2'b10:   weight_cnt_d = weight_cnt_q + CNT_W'(1);
                2'b01:   weight_cnt_d = weight_cnt_q - CNT_W'(1);
                default: weight_cnt_d = weight_cnt_q;
            endcase

            if (refuse && (underflow_q != '1))
                underflow_d = underflow_q + REG_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_wr_ptr_q   <= '0;
            data_rd_ptr_q   <= '0;
            data_cnt_q      <= '0;
            weight_wr_ptr_q <= '0;
            weight_rd_ptr_q <= '0;
            weight_cnt_q    <= '0;
            underflow_q     <= '0;
            data_out_q      <= '0;
            weight_out_q    <= '0;
            val_q           <= 1'b0;
        end else begin
            data_wr_ptr_q   <= data_wr_ptr_d;
            data_rd_ptr_q   <= data_rd_ptr_d;
            data_cnt_q      <= data_cnt_d;
            weight_wr_ptr_q <= weight_wr_ptr_d;
            weight_rd_ptr_q <= weight_rd_ptr_d;
            weight_cnt_q    <= weight_cnt_d;
            underflow_q     <= underflow_d;
            data_out_q      <= data_out_d;
            weight_out_q    <= weight_out_d;
            val_q           <= val_d;
        end
    end

    // Storage needs no reset; ready is low during rst and i_clear so no write
    // can land then.
    always_ff @(posedge clk) begin
        if (data_push)   data_mem[data_wr_ptr_q]     <= s_data;
        if (weight_push) weight_mem[weight_wr_ptr_q] <= s_weight;
    end

    assign o_data          = data_out_q;
    assign o_weight        = weight_out_q;
    assign o_data_val      = val_q;
    assign o_weight_val    = val_q;
    assign o_data_cnt      = data_cnt_q;
    assign o_weight_cnt    = weight_cnt_q;
    assign o_underflow_cnt = underflow_q;

endmodule
